// File: rtl/alu_op_sequencer.sv
`default_nettype none
// =============================================================================
// alu_op_sequencer: walks one request at a time through an external 32-bit
// ALU, settling the inputs before sampling; SLT takes a SUB pass then a less pass.
// Revision: 1.0 - initial release
// =============================================================================

module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_c,
  output logic [31:0] alu_less,
  output logic        ALUop0,
  output logic        ALUop1,
  output logic        ALUop2,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_carryout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic        rsp_overflow,
  output logic        rsp_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    SLT2  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [31:0] alu_c_q, alu_c_d;
  logic [31:0] alu_less_q, alu_less_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic        slt_q, slt_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_carry_q, rsp_carry_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_overflow_q, rsp_overflow_d;
  logic        rsp_error_q, rsp_error_d;
  logic        pass_ovf;
  logic        is_last;
  logic        unused_carry;

  // Only the top two carries matter: bit 31 is carry-out, 31^30 is overflow.
  assign unused_carry = ^alu_carryout[29:0];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_c_d        = alu_c_q;
    alu_less_d     = alu_less_q;
    alu_op_d       = alu_op_q;
    slt_d          = slt_q;
    rsp_result_d   = rsp_result_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_error_d    = rsp_error_q;
    pass_ovf       = alu_carryout[31] ^ alu_carryout[30];
    is_last        = (cnt_q == LAST_CNT);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: begin
              alu_a_d  = req_a;
              alu_b_d  = req_b;
              alu_c_d  = (req_op == OP_SUB || req_op == OP_SLT) ? 32'd1 : 32'd0;
              alu_op_d = (req_op == OP_SLT) ? OP_SUB : req_op;
              slt_d    = (req_op == OP_SLT);
              cnt_d    = 4'd0;
              state_d  = DRIVE;
            end
            default: begin
              // Illegal opcode: leave the ALU drive untouched, answer at once.
              rsp_result_d   = 32'd0;
              rsp_carry_d    = 1'b0;
              rsp_zero_d     = 1'b0;
              rsp_overflow_d = 1'b0;
              rsp_error_d    = 1'b1;
              state_d        = RESP;
            end
          endcase
        end
      end
      DRIVE: begin
        if (is_last) begin
          cnt_d          = 4'd0;
          rsp_carry_d    = alu_carryout[31];
          rsp_overflow_d = alu_op_q[1] & pass_ovf;
          rsp_error_d    = 1'b0;
          if (slt_q) begin
            alu_op_d   = OP_SLT;
            alu_less_d = {31'd0, alu_result[31] ^ pass_ovf};
            state_d    = SLT2;
          end else begin
            rsp_result_d = alu_result;
            rsp_zero_d   = (alu_result == 32'd0);
            state_d      = RESP;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SLT2: begin
        if (is_last) begin
          cnt_d        = 4'd0;
          rsp_result_d = alu_result;
          rsp_zero_d   = (alu_result == 32'd0);
          alu_less_d   = 32'd0;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      alu_a_q        <= 32'd0;
      alu_b_q        <= 32'd0;
      alu_c_q        <= 32'd0;
      alu_less_q     <= 32'd0;
      alu_op_q       <= 3'd0;
      slt_q          <= 1'b0;
      rsp_result_q   <= 32'd0;
      rsp_carry_q    <= 1'b0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_c_q        <= alu_c_d;
      alu_less_q     <= alu_less_d;
      alu_op_q       <= alu_op_d;
      slt_q          <= slt_d;
      rsp_result_q   <= rsp_result_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_error_q    <= rsp_error_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_c        = alu_c_q;
  assign alu_less     = alu_less_q;
  assign ALUop0       = alu_op_q[0];
  assign ALUop1       = alu_op_q[1];
  assign ALUop2       = alu_op_q[2];
  assign rsp_result   = rsp_result_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_error    = rsp_error_q;

endmodule

`default_nettype wire
